tri_fetch: RTL
==============

TRI_FETCH -- requirements
Module: tri_fetch

Interface
REQ-001 SHALL have parameter intBits, default 8, integer bits of a coordinate word.
REQ-002 SHALL have parameter decimalBits, default 8, fractional bits; coordinate width W = intBits+decimalBits+1 (signed).
REQ-003 SHALL have parameter colorDepth, default 4, bits per vertex colour; 3*colorDepth <= W.
REQ-004 SHALL have parameter addrBits, default 10, triangle-memory address width.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to fetch a triangle list.
REQ-008 SHALL have port abort, input, 1, synchronous cancel of the current list.
REQ-009 SHALL have port base_addr, input, addrBits, word address of the first triangle, sampled on start.
REQ-010 SHALL have port tri_count, input, 8, number of triangles in the list, sampled on start.
REQ-011 SHALL have port mem_rd, output, 1, read strobe to synchronous triangle memory.
REQ-012 SHALL have port mem_addr, output, addrBits, read address.
REQ-013 SHALL have port mem_rdata, input, W, read data, valid exactly one cycle after mem_rd.
REQ-014 SHALL have ports vert_0_x..vert_2_z, output, W signed each (9 ports), assembled vertex coordinates for the downstream triangle renderer.
REQ-015 SHALL have ports col_0, col_1, col_2, output, colorDepth each, vertex colours.
REQ-016 SHALL have ports tri_valid (output, 1) and tri_ready (input, 1), triangle handshake.
REQ-017 SHALL have port tri_index, output, 8, index of the presented triangle within the list.
REQ-018 SHALL have ports busy (output, 1, list in progress) and done (output, 1, one-cycle end-of-list pulse).

Function
REQ-019 SHALL store each triangle as 10 consecutive words: v0x,v0y,v0z,v1x,v1y,v1z,v2x,v2y,v2z, colour word.
REQ-020 SHALL unpack colour word as col_0=[colorDepth-1:0], col_1=next colorDepth bits, col_2=next colorDepth bits; upper bits ignored.
REQ-021 SHALL implement states IDLE, FETCH, PRESENT, DONE.
REQ-022 SHALL in IDLE on start with tri_count>0 latch base_addr/tri_count, set busy, enter FETCH next cycle.
REQ-023 SHALL in IDLE on start with tri_count=0 issue no reads and pulse done the next cycle.
REQ-024 SHALL in FETCH assert mem_rd for 10 consecutive cycles, addresses base_addr+10*i+k, k=0..9, i=tri_index.
REQ-025 SHALL capture each mem_rdata into its output register the cycle after its read; outputs hold the previous triangle until overwritten.
REQ-026 SHALL assert tri_valid the cycle after the 10th word is captured (11 cycles after first mem_rd) and enter PRESENT.
REQ-027 SHALL hold tri_valid, vertex, colour and tri_index stable in PRESENT until tri_valid&&tri_ready sampled high.
REQ-028 SHALL on handshake deassert tri_valid next cycle; if more triangles remain, increment tri_index and enter FETCH that cycle, else enter DONE.
REQ-029 SHALL in DONE assert done for exactly one cycle, clear busy, return to IDLE.
REQ-030 SHALL wrap mem_addr modulo 2^addrBits without error.
REQ-031 SHALL ignore start while busy.
REQ-032 SHALL on abort (any non-IDLE state) deassert mem_rd, tri_valid, busy next cycle and return to IDLE with no done pulse; abort wins over a simultaneous handshake.
REQ-033 SHALL tolerate tri_ready high before tri_valid without effect.

Reset
REQ-034 SHALL on rst_n low immediately force state IDLE and all outputs (mem_rd, mem_addr, vertices, colours, tri_valid, tri_index, busy, done) to 0, including mid-fetch.
REQ-035 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-036 SHALL cover: start, base_addr=0, tri_count=1, mem word n = n, tri_ready=1 -> addresses 0..9, tri_valid 11 cycles after first read, v0x=0..v2z=8, colours from word 9, done one cycle after handshake.
REQ-037 SHALL cover: tri_count=3, tri_ready held low 5 cycles per triangle -> outputs stable while waiting, tri_index 0,1,2, reads at base+0,+10,+20.
REQ-038 SHALL cover: tri_count=0 -> no mem_rd, done pulse one cycle after start, busy never high.
REQ-039 SHALL cover: base_addr=1020, addrBits=10 -> mem_addr sequence 1020..1023,0..5.
REQ-040 SHALL cover: abort at 4th read, and rst_n low mid-PRESENT -> outputs/state as REQ-032/REQ-034, subsequent start runs cleanly.
REQ-041 SHALL cover: start pulsed while busy -> ignored, list completes unchanged.

Source files
------------

// File: rtl/tri_fetch.sv
// Triangle-list fetcher: reads 10-word triangle records from synchronous memory,
// unpacks vertices and colours, and presents each triangle over a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | issuing the 10 reads of one triangle, then one cycle for the last capture
// PRESENT | triangle presented, waiting for tri_ready
// DONE    | one-cycle end-of-list pulse
module tri_fetch #(
  parameter int intBits     = 8,
  parameter int decimalBits = 8,
  parameter int colorDepth  = 4,
  parameter int addrBits    = 10
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [addrBits-1:0]                  base_addr,
  input  logic [7:0]                           tri_count,
  output logic                                 mem_rd,
  output logic [addrBits-1:0]                  mem_addr,
  input  logic [intBits+decimalBits:0]         mem_rdata,
  output logic signed [intBits+decimalBits:0]  vert_0_x,
  output logic signed [intBits+decimalBits:0]  vert_0_y,
  output logic signed [intBits+decimalBits:0]  vert_0_z,
  output logic signed [intBits+decimalBits:0]  vert_1_x,
  output logic signed [intBits+decimalBits:0]  vert_1_y,
  output logic signed [intBits+decimalBits:0]  vert_1_z,
  output logic signed [intBits+decimalBits:0]  vert_2_x,
  output logic signed [intBits+decimalBits:0]  vert_2_y,
  output logic signed [intBits+decimalBits:0]  vert_2_z,
  output logic [colorDepth-1:0]                col_0,
  output logic [colorDepth-1:0]                col_1,
  output logic [colorDepth-1:0]                col_2,
  output logic                                 tri_valid,
  input  logic                                 tri_ready,
  output logic [7:0]                           tri_index,
  output logic                                 busy,
  output logic                                 done
);

  localparam int W  = intBits + decimalBits + 1;
  localparam int CW = 3 * colorDepth;

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  state_t                state, state_nx;
  logic [3:0]            word_k;
  logic [3:0]            cap_k;
  logic                  cap_en;
  logic [addrBits-1:0]   tri_addr;
  logic [7:0]            tri_left;
  logic signed [W-1:0]   vreg [9];
  logic [CW-1:0]         cword;
  logic                  launch;
  logic                  advance;

  always_comb begin
    state_nx  = state;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    tri_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    launch    = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch   = 1'b1;
          state_nx = (tri_count == 8'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        busy = 1'b1;
        // word_k == 10 is the slot where the final word is still in flight
        if (word_k == 4'd10) begin
          state_nx = PRESENT;
        end else begin
          mem_rd   = 1'b1;
          mem_addr = tri_addr + addrBits'(word_k);
        end
      end
      PRESENT: begin
        busy      = 1'b1;
        tri_valid = 1'b1;
        if (tri_ready) begin
          if (tri_left == 8'd0) begin
            state_nx = DONE;
          end else begin
            state_nx = FETCH;
            advance  = 1'b1;
          end
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      advance  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_k    <= '0;
      cap_k     <= '0;
      cap_en    <= 1'b0;
      tri_addr  <= '0;
      tri_left  <= '0;
      tri_index <= '0;
      cword     <= '0;
      for (int j = 0; j < 9; j++) vreg[j] <= '0;
    end else begin
      cap_en <= mem_rd && !abort;
      cap_k  <= word_k;
      word_k <= (state == FETCH && state_nx == FETCH) ? word_k + 4'd1 : 4'd0;
      if (launch) begin
        tri_addr  <= base_addr;
        tri_left  <= tri_count - 8'd1;
        tri_index <= 8'd0;
      end else if (advance) begin
        tri_addr  <= tri_addr + addrBits'(4'd10);
        tri_left  <= tri_left - 8'd1;
        tri_index <= tri_index + 8'd1;
      end
      if (cap_en) begin
        if (cap_k == 4'd9) cword <= mem_rdata[CW-1:0];
        else               vreg[cap_k] <= mem_rdata;
      end
    end
  end

  assign vert_0_x = vreg[0];
  assign vert_0_y = vreg[1];
  assign vert_0_z = vreg[2];
  assign vert_1_x = vreg[3];
  assign vert_1_y = vreg[4];
  assign vert_1_z = vreg[5];
  assign vert_2_x = vreg[6];
  assign vert_2_y = vreg[7];
  assign vert_2_z = vreg[8];
  assign col_0    = cword[colorDepth-1:0];
  assign col_1    = cword[2*colorDepth-1:colorDepth];
  assign col_2    = cword[CW-1:2*colorDepth];

endmodule
